// File: rtl/disp_pkg.sv
// Shared types, constants and the leading-zero mask helper for the display scan block.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [7:0] ANODE_OFF  = 8'hFF;
  localparam logic       SEG_DP_OFF = 1'b1;

  // Bit i set means digit i may be lit: digit 0 always, others only up to the
  // most significant nonzero digit among the first n digits.
  function automatic logic [7:0] lz_show_mask(input logic [31:0] data, input int n);
    logic seen;
    seen = 1'b0;
    lz_show_mask = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n && data[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_show_mask[i] = seen || (i == 0);
    end
  endfunction

endpackage

// File: rtl/disp_tick_cnt.sv
// Slot counter: runs 0..CLKS_PER_DIGIT-1 while run=1, held at 0 otherwise.
// Latency: compare flags are combinational on the count; no backpressure.
module disp_tick_cnt #(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(CLKS_PER_DIGIT);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLKS_PER_DIGIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (!run || cnt == SLOT_LAST) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign blank_done = (cnt == BLANK_LAST);
  assign slot_done  = (cnt == SLOT_LAST);

endmodule

// File: rtl/disp_scan.sv
// Multiplexed 7-segment scan with frame-synchronous shadow load; DISP_SCAN_LZ_BLANK_EN adds leading-zero blanking.
// Latency: outputs registered, one frame worst-case load-to-ack; no backpressure (last load wins).
module disp_scan
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int BLANK_CLKS     = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] disp_data, shadow_data, disp_data_nxt;
  logic [NUM_DIGITS-1:0]   disp_dp, shadow_dp, disp_dp_nxt;
  logic                    pending, commit;
  logic                    blank_done, slot_done, show;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;
  logic [3:0]              digit_nxt;

  disp_tick_cnt #(
    .CLKS_PER_DIGIT(CLKS_PER_DIGIT),
    .BLANK_CLKS    (BLANK_CLKS)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (en && state != IDLE),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
        end
        BLANK: if (blank_done) state_nxt = DRIVE;
        DRIVE: if (slot_done) begin
          state_nxt = BLANK;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Commit ignores en so a frame end coinciding with disable still lands.
  assign commit = pending &&
                  (state == IDLE || (state == DRIVE && slot_done && idx == IDX_LAST));
  assign disp_data_nxt = commit ? shadow_data : disp_data;
  assign disp_dp_nxt   = commit ? shadow_dp   : disp_dp;

`ifdef DISP_SCAN_LZ_BLANK_EN
  logic [31:0] disp_pad;
  logic [7:0]  show_mask;
  always_comb begin
    disp_pad = '0;
    disp_pad[4*NUM_DIGITS-1:0] = disp_data;
    show_mask = lz_show_mask(disp_pad, NUM_DIGITS);
  end
  assign show = show_mask[idx_nxt];
`else
  assign show = 1'b1;
`endif

  // Digit tracks the upcoming index so the decoder settles during BLANK.
  always_comb begin
    digit_nxt = disp_data_nxt[4*idx_nxt +: 4];
    an_nxt    = ANODE_OFF[NUM_DIGITS-1:0];
    dp_nxt    = SEG_DP_OFF;
    if (state_nxt == DRIVE && show) begin
      an_nxt[idx_nxt] = 1'b0;
      dp_nxt          = ~disp_dp[idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      digit       <= '0;
      an_n        <= ANODE_OFF[NUM_DIGITS-1:0];
      dp_n        <= SEG_DP_OFF;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      load_ack  <= commit;
      digit     <= digit_nxt;
      an_n      <= an_nxt;
      dp_n      <= dp_nxt;
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
        pending     <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomized and directed bench for disp_scan against a frame-position reference model.
module tb_disp_scan;

  localparam int N   = 4;
  localparam int CPD = 8;
  localparam int BL  = 2;
  localparam int FRAME = N * CPD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic          load_ack;
  logic [3:0]    digit;
  logic [3:0]    an_n;
  logic          dp_n;

  disp_scan #(.NUM_DIGITS(N), .CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BL)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .data_in (data_in),
    .dp_in   (dp_in),
    .load    (load),
    .load_ack(load_ack),
    .digit   (digit),
    .an_n    (an_n),
    .dp_n    (dp_n)
  );

  always #5 clk = ~clk;

  // Model: m_p counts cycles since the scan left idle; slot/index/phase derive from it.
  int          m_p;
  bit          m_idle;
  bit          m_pend;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_dispdp;
  bit          m_ack;
  int          errors = 0;
  int          checks = 0;
  int          acks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_p = 0; m_idle = 1; m_pend = 0; m_ack = 0;
    m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0;
  endfunction

  function automatic bit lz_shown(input int idx);
`ifdef DISP_SCAN_LZ_BLANK_EN
    int hi;
    hi = 0;
    for (int j = 0; j < N; j++) if (m_disp[4*j +: 4] != 4'h0) hi = j;
    return idx <= hi;
`else
    return 1'b1;
`endif
  endfunction

  task automatic compare();
    int idx;
    logic [3:0] e_an;
    logic e_dp;
    idx  = m_idle ? 0 : (m_p / CPD) % N;
    e_an = 4'hF;
    e_dp = 1'b1;
    if (!m_idle && (m_p % CPD) >= BL && lz_shown(idx)) begin
      e_an[idx] = 1'b0;
      e_dp      = ~m_dispdp[idx];
    end
    check_val("an_n", 32'(an_n), 32'(e_an));
    check_val("dp_n", 32'(dp_n), 32'(e_dp));
    check_val("digit", 32'(digit), 32'(m_disp[4*idx +: 4]));
    check_val("load_ack", 32'(load_ack), 32'(m_ack));
    if (load_ack) acks++;
  endtask

  task automatic step();
    bit commit;
    @(posedge clk);
    if (!rst) begin
      commit = m_pend && (m_idle || (m_p % FRAME == FRAME - 1));
      if (commit) begin m_disp = m_sh; m_dispdp = m_shdp; end
      m_ack = commit;
      if (load) begin m_sh = data_in; m_shdp = dp_in; m_pend = 1; end
      else if (commit) m_pend = 0;
      if (en) begin
        if (m_idle) begin m_idle = 0; m_p = 0; end
        else m_p++;
      end else m_idle = 1;
    end
    #1 compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    data_in = d; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the model sits at frame position pos; expiry counts as a failure.
  task automatic seek(input string tag, input int pos);
    for (int k = 0; k < 2*FRAME && (m_idle || m_p % FRAME != pos); k++) step();
    check_val(tag, 32'(!m_idle && m_p % FRAME == pos), 32'd1);
  endtask

  initial begin
    int a0;
    model_reset();
    run(2);
    rst = 1'b0;

    // 1: idle load acks next cycle, then scan 1,2,3,4
    do_load(16'h4321, 4'h0);
    step();
    check_val("s1_ack", 32'(load_ack), 32'd1);
    en = 1'b1;
    run(2*FRAME + 4);

    // 2: two loads mid-frame, single ack at wrap, last wins
    seek("s2_sync", CPD + 2);
    a0 = acks;
    do_load(16'h9876, 4'h0);
    run(2);
    do_load(16'h5555, 4'h0);
    run(2*FRAME);
    check_val("s2_acks", 32'(acks - a0), 32'd1);
    check_val("s2_disp", 32'(m_disp), 32'h5555);

    // 3: load on commit cycle commits next frame
    do_load(16'h2222, 4'h0);
    seek("s3_sync", FRAME - 1);
    a0 = acks;
    do_load(16'h1111, 4'h0);
    check_val("s3_ack1", 32'(load_ack), 32'd1);
    run(2*FRAME);
    check_val("s3_acks", 32'(acks - a0), 32'd2);

    // 4: decimal point on digit 2 only
    do_load(16'h8642, 4'b0100);
    run(2*FRAME + 2);

    // 5: disable mid-drive, restart, then async reset with a load pending
    seek("s5_sync", 2*CPD + 4);
    en = 1'b0;
    step();
    check_val("s5_off", 32'(an_n), 32'hF);
    run(3);
    en = 1'b1;
    run(CPD + 3);
    do_load(16'h7777, 4'h0);
    run(2);
    a0 = acks;
    rst = 1'b1;
    #1;
    check_val("s5_rst_an", 32'(an_n), 32'hF);
    check_val("s5_rst_dp", 32'(dp_n), 32'd1);
    check_val("s5_rst_dig", 32'(digit), 32'd0);
    check_val("s5_rst_ack", 32'(load_ack), 32'd0);
    model_reset();
    run(2);
    rst = 1'b0;
    en = 1'b0;
    run(FRAME);
    check_val("s5_no_ack", 32'(acks - a0), 32'd0);

    // 6: leading-zero patterns (plain full drive without the option)
    do_load(16'h0050, 4'b0111);
    en = 1'b1;
    run(FRAME + 4);
    en = 1'b0;
    do_load(16'h0000, 4'b1111);
    en = 1'b1;
    run(FRAME + 4);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      load    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      step();
    end
    load = 1'b0;
    run(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
